// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: widths, FSM states and ALU control codes.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ALUC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 6'h00;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 6'h08;
  localparam logic [ALUC_W-1:0] ALU_AND  = 6'h02;
  localparam logic [ALUC_W-1:0] ALU_OR   = 6'h0A;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 6'h03;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 6'h0B;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 6'h04;
  localparam logic [ALUC_W-1:0] ALU_LUI  = 6'h0C;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 6'h05;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 6'h0D;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 6'h1D;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  int unsigned idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_o && req_i[PTR_W'(idx)]) begin
        any_o                = 1'b1;
        gnt_idx_o            = PTR_W'(idx);
        gnt_o[PTR_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among NUM_REQ requesters, one operation in flight at a time.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = alu_pkg::XLEN,
  parameter int unsigned ALUC_W  = alu_pkg::ALUC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*XLEN-1:0]   req_a,
  input  logic [NUM_REQ*XLEN-1:0]   req_b,
  input  logic [NUM_REQ*ALUC_W-1:0] req_aluc,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [ALUC_W-1:0]         alu_aluc,
  input  logic [XLEN-1:0]           alu_result,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [XLEN-1:0]           rsp_result,
  output logic                      rsp_zero
);

  import alu_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    grant_id_q, grant_id_d;
  logic [XLEN-1:0]     op_a_q, op_a_d;
  logic [XLEN-1:0]     op_b_q, op_b_d;
  logic [ALUC_W-1:0]   op_aluc_q, op_aluc_d;
  logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // Grants are offered only while idle; the handshake edge latches the winner's payload.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_aluc_d    = op_aluc_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          grant_id_d = gnt_idx;
          op_a_d     = req_a[32'(gnt_idx)*XLEN +: XLEN];
          op_b_d     = req_b[32'(gnt_idx)*XLEN +: XLEN];
          op_aluc_d  = req_aluc[32'(gnt_idx)*ALUC_W +: ALUC_W];
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = NUM_REQ'(1) << grant_id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
          if (32'(grant_id_q) == NUM_REQ - 1) rr_ptr_d = '0;
          else                                rr_ptr_d = grant_id_q + PTR_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_aluc_q    <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_aluc_q    <= op_aluc_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // ALU inputs come straight from the op registers so they hold the last op between grants.
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_aluc   = op_aluc_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and a rotation-based reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;
  localparam int unsigned C = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*C-1:0] req_aluc;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_result;
  logic [C-1:0]   alu_aluc;
  logic           alu_zero, rsp_zero;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] c);
    logic signed [31:0] sa;
    logic signed [31:0] sr;
    sa = a;
    sr = sa >>> b[4:0];
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {31'd0, (a < b)};
      ALU_LUI:  return {b[15:0], 16'h0000};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sr;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_aluc);
  assign alu_zero   = (alu_result == 32'd0);

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(W), .ALUC_W(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_aluc   (req_aluc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_aluc   (alu_aluc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c);
    req_a[idx*W +: W]    = a;
    req_b[idx*W +: W]    = b;
    req_aluc[idx*C +: C] = c;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0; req_b = '0; req_aluc = '0;
    rst_n = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  // Single op on one requester with rsp_ready held high from the start.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] c, input logic [31:0] er, input logic ez);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    set_req(idx, a, b, c);
    req_valid = oh;
    rsp_ready = '1;
    #1;
    check("op_req_ready", 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    #1;
    check("op_exec_no_rsp", 32'(rsp_valid), 32'd0);
    check("op_alu_a", alu_a, a);
    check("op_alu_b", alu_b, b);
    check("op_alu_aluc", 32'(alu_aluc), 32'(c));
    step();
    check("op_rsp_valid", 32'(rsp_valid), 32'(oh));
    check("op_rsp_result", rsp_result, er);
    check("op_rsp_zero", 32'(rsp_zero), 32'(ez));
    step();
    check("op_rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  c;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[9];
  logic [5:0] ops[11];

  // Random-phase reference model state.
  bit          busy, acc_last;
  int          owner, age, ptr, win_last, w;
  logic [31:0] exp_res;
  logic [N-1:0] rr_last, exp_ready, exp_v;
  bit          pv[N];
  logic [31:0] pa[N], pb[N];
  logic [5:0]  pc[N];

  initial begin
    vecs[0] = '{0, 32'd5,          32'd7,          ALU_ADD,  32'd12,         1'b0};
    vecs[1] = '{1, 32'd9,          32'd9,          ALU_SUB,  32'd0,          1'b1};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,          ALU_SLT,  32'd1,          1'b0};
    vecs[3] = '{1, 32'h0000_F0F0,  32'h0000_FF00,  ALU_XOR,  32'h0000_0FF0,  1'b0};
    vecs[4] = '{0, 32'd1,          32'd31,         ALU_SLL,  32'h8000_0000,  1'b0};
    vecs[5] = '{1, 32'h8000_0000,  32'd4,          ALU_SRL,  32'h0800_0000,  1'b0};
    vecs[6] = '{0, 32'd0,          32'd0,          ALU_OR,   32'd0,          1'b1};
    vecs[7] = '{1, 32'd0,          32'h0000_1234,  ALU_LUI,  32'h1234_0000,  1'b0};
    vecs[8] = '{0, 32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 32'd0,          1'b1};
    ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA};

    do_reset();
    for (int i = 0; i < 9; i++)
      do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r, vecs[i].z);

    // Both valid from reset, held continuously: strict rotation 0,1,0,1.
    do_reset();
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'h8000_0000, 32'd4, ALU_SRA);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] oh;
      oh = N'(1) << (k % 2);
      #1;
      check("rot_req_ready", 32'(req_ready), 32'(oh));
      step();
      check("rot_exec_ready", 32'(req_ready), 32'd0);
      step();
      check("rot_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("rot_rsp_result", rsp_result, (k % 2 == 0) ? 32'd2 : 32'hF800_0000);
      step();
    end
    req_valid = '0;

    // Backpressure: response held, no new grant to the waiting requester.
    do_reset();
    set_req(0, 32'd1, 32'hFFFF_FFFF, ALU_SLTU);
    set_req(1, 32'd2, 32'd3, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_result", rsp_result, 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    check("bp_req1_result", rsp_result, 32'd5);
    check("bp_req1_valid", 32'(rsp_valid), 32'h2);
    step();

    // Reset during EXEC drops the op.
    set_req(0, 32'd10, 32'd20, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_result", rsp_result, 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op(0, 32'd3, 32'd4, ALU_ADD, 32'd7, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    busy = 0; acc_last = 0; ptr = 0; rr_last = '0; owner = 0; age = 0; win_last = 0;
    exp_res = '0;
    for (int i = 0; i < N; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; pc[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (busy) begin
        if (age >= 1 && rr_last[owner]) begin
          busy = 0;
          ptr  = (owner + 1) % N;
        end else begin
          age++;
        end
      end else if (acc_last) begin
        busy      = 1;
        owner     = win_last;
        age       = 0;
        exp_res   = alu_ref(pa[owner], pb[owner], pc[owner]);
        pv[owner] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(3, 0) == 0) ? pa[i] : $urandom;
          pc[i] = ops[$urandom_range(10, 0)];
        end
        req_valid[i] = pv[i];
        set_req(i, pa[i], pb[i], pc[i]);
      end
      rsp_ready = N'($urandom_range(3, 0));
      #1;
      exp_ready = '0;
      acc_last  = 0;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          w = (ptr + k) % N;
          if (!acc_last && pv[w]) begin
            acc_last     = 1;
            win_last     = w;
            exp_ready[w] = 1'b1;
          end
        end
      end
      exp_v = (busy && age >= 1) ? (N'(1) << owner) : '0;
      check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (busy && age >= 1) begin
        check("rnd_rsp_result", rsp_result, exp_res);
        check("rnd_rsp_zero", 32'(rsp_zero), 32'(exp_res == 32'd0));
      end
      rr_last = rsp_ready;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
